mem_l1_arb: RTL and testbench

MEM_L1_ARB -- requirements
Module: mem_l1_arb

---
 rtl/mem_l1_arb.sv | 177 +++++++++++++++++
 tb/tb_mem_l1_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_l1_arb.sv
// L1 requester arbiter: round-robin grant of NPORT requester ports onto a single memory bus.
// Optional feature: define MEM_L1_ARB_FASTDONE_EN to add a DONE state that latches load data
// on bus OK and frees the bus while the owner finishes the handshake.
module mem_l1_arb #(
  parameter int unsigned NPORT = 3,
  parameter int unsigned AW    = 48,
  parameter int unsigned DW    = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NPORT*AW-1:0] reqAddr,
  input  logic [NPORT*AW-1:0] reqAddrB,
  input  logic [NPORT*5-1:0]  reqOpm,
  input  logic [NPORT*DW-1:0] reqData,
  output logic [NPORT*2-1:0]  rspOK,
  output logic [DW-1:0]       rspData,
  output logic [AW-1:0]       memAddr,
  output logic [AW-1:0]       memAddrB,
  output logic [15:0]         memOpm,
  output logic [DW-1:0]       memDataOut,
  input  logic [DW-1:0]       memDataIn,
  input  logic [1:0]          memOK,
  output logic [63:0]         regOutExc,
  output logic [1:0]          grantId
);

  localparam logic [4:0] OpmReady = 5'h00;
  localparam logic [4:0] OpmFault = 5'h1F;
  localparam logic [1:0] OkReady  = 2'd0;
  localparam logic [1:0] OkOk     = 2'd1;
  localparam logic [1:0] OkFault  = 2'd3;

`ifdef MEM_L1_ARB_FASTDONE_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  logic [DW-1:0] doneBufQ, doneBufD;
`else
  typedef enum logic [1:0] {StIdle, StBusy} state_e;
`endif

  state_e      stateQ, stateD;
  logic [1:0]  rrPtrQ, rrPtrD;
  logic [1:0]  ownerQ, ownerD;
  logic [63:0] excQ, excD;

  logic          grantValid;
  logic [1:0]    grantIdx;
  logic          active;
  logic [1:0]    owner;
  logic [4:0]    ownOpm;
  logic [AW-1:0] ownAddr;

  // Round-robin search starting at rrPtr; only meaningful in IDLE and never while in reset.
  always_comb begin
    int unsigned c;
    grantValid = 1'b0;
    grantIdx   = 2'd0;
    c          = 0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      c = 32'(rrPtrQ) + i;
      if (c >= NPORT) c = c - NPORT;
      if (!grantValid && reqOpm[c*5 +: 5] != OpmReady) begin
        grantValid = 1'b1;
        grantIdx   = c[1:0];
      end
    end
    if (reset || stateQ != StIdle) grantValid = 1'b0;
  end

  // Select the port currently routed to the bus (fresh grant in IDLE, latched owner otherwise).
  always_comb begin
    active = 1'b0;
    owner  = ownerQ;
    if (stateQ == StIdle) begin
      active = grantValid;
      owner  = grantIdx;
    end else if (stateQ == StBusy) begin
      active = 1'b1;
    end
    ownOpm  = reqOpm[owner*5 +: 5];
    ownAddr = reqAddr[owner*AW +: AW];
  end

  // Bus and response routing; non-owners always see READY.
  always_comb begin
    memAddr    = '0;
    memAddrB   = '0;
    memOpm     = 16'h0;
    memDataOut = '0;
    rspOK      = '0;
    rspData    = memDataIn;
    grantId    = owner;
    if (active) begin
      memAddr              = ownAddr;
      memAddrB             = reqAddrB[owner*AW +: AW];
      memOpm               = {11'h0, ownOpm};
      memDataOut           = reqData[owner*DW +: DW];
      rspOK[owner*2 +: 2]  = memOK;
    end
`ifdef MEM_L1_ARB_FASTDONE_EN
    if (stateQ == StDone) begin
      rspOK[owner*2 +: 2] = OkOk;
      rspData             = doneBufQ;
    end
`endif
  end

  // Next-state, round-robin pointer and fault record.
  always_comb begin
    stateD = stateQ;
    rrPtrD = rrPtrQ;
    ownerD = ownerQ;
`ifdef MEM_L1_ARB_FASTDONE_EN
    doneBufD = doneBufQ;
`endif
    case (stateQ)
      StIdle: begin
        if (grantValid) begin
          stateD = StBusy;
          ownerD = grantIdx;
        end
      end
      StBusy: begin
`ifdef MEM_L1_ARB_FASTDONE_EN
        if (memOK == OkOk) begin
          stateD   = StDone;
          doneBufD = memDataIn;
        end else
`endif
        if (ownOpm == OpmReady && memOK == OkReady) begin
          stateD = StIdle;
          rrPtrD = (ownerQ == 2'(NPORT - 1)) ? 2'd0 : ownerQ + 2'd1;
        end
      end
`ifdef MEM_L1_ARB_FASTDONE_EN
      StDone: begin
        if (ownOpm == OpmReady && memOK == OkReady) begin
          stateD = StIdle;
          rrPtrD = (ownerQ == 2'(NPORT - 1)) ? 2'd0 : ownerQ + 2'd1;
        end
      end
`endif
      default: stateD = StIdle;
    endcase

    // Critical bus faults take priority over a requester-raised fault.
    excD = 64'h0;
    if (memOK == OkFault && memDataIn[15]) begin
      excD = {48'(memAddr), memDataIn[15:0]};
    end else if (active && ownOpm == OpmFault) begin
      excD = {48'(ownAddr), 12'h800, ownAddr[1] ? 4'h2 : 4'h1};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= StIdle;
      rrPtrQ <= 2'd0;
      ownerQ <= 2'd0;
      excQ   <= 64'h0;
`ifdef MEM_L1_ARB_FASTDONE_EN
      doneBufQ <= '0;
`endif
    end else begin
      stateQ <= stateD;
      rrPtrQ <= rrPtrD;
      ownerQ <= ownerD;
      excQ   <= excD;
`ifdef MEM_L1_ARB_FASTDONE_EN
      doneBufQ <= doneBufD;
`endif
    end
  end

  assign regOutExc = excQ;

endmodule

// File: tb/tb_mem_l1_arb.sv
// Self-checking bench for mem_l1_arb: directed scenarios plus randomized requests checked
// against a transaction-level round-robin model.
module tb_mem_l1_arb;

  localparam int N  = 3;
  localparam int AW = 48;
  localparam int DW = 128;

  logic              clock = 1'b0;
  logic              reset;
  logic [N*AW-1:0]   reqAddr, reqAddrB;
  logic [N*5-1:0]    reqOpm;
  logic [N*DW-1:0]   reqData;
  logic [N*2-1:0]    rspOK;
  logic [DW-1:0]     rspData, memDataOut, memDataIn;
  logic [AW-1:0]     memAddr, memAddrB;
  logic [15:0]       memOpm;
  logic [1:0]        memOK, grantId;
  logic [63:0]       regOutExc;

  mem_l1_arb #(.NPORT(N), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset), .reqAddr(reqAddr), .reqAddrB(reqAddrB), .reqOpm(reqOpm),
    .reqData(reqData), .rspOK(rspOK), .rspData(rspData), .memAddr(memAddr),
    .memAddrB(memAddrB), .memOpm(memOpm), .memDataOut(memDataOut), .memDataIn(memDataIn),
    .memOK(memOK), .regOutExc(regOutExc), .grantId(grantId)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          rrPtr;
  int          curOwner;
  logic [63:0] excExp;
  int          schedLen;
  logic [1:0]  schedOk[8];
  logic [127:0] schedDat[8];

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] opmOf(input int p);
    return reqOpm[p*5 +: 5];
  endfunction

  function automatic logic [AW-1:0] addrOf(input int p);
    return reqAddr[p*AW +: AW];
  endfunction

  function automatic int pickGrant();
    for (int i = 0; i < N; i++) begin
      int p;
      p = (rrPtr + i) % N;
      if (opmOf(p) != 5'h00) return p;
    end
    return 0;
  endfunction

  function automatic bit anyReq();
    return reqOpm != '0;
  endfunction

  task automatic settle();
    @(negedge clock);
  endtask

  // Advance one clock; the fault record expected next comes from what the bus/owner showed now.
  task automatic tick();
    logic [63:0]   nx;
    logic [AW-1:0] ra;
    nx = 64'h0;
    ra = (curOwner >= 0) ? addrOf(curOwner) : '0;
    if (!reset) begin
      if (memOK == 2'd3 && memDataIn[15]) nx = {ra, memDataIn[15:0]};
      else if (curOwner >= 0 && opmOf(curOwner) == 5'h1F) nx = {ra, 12'h800, ra[1] ? 4'h2 : 4'h1};
    end
    @(posedge clock);
    #1;
    excExp = nx;
  endtask

  task automatic checkCycle();
    checkVal("exc", regOutExc, excExp);
    checkVal("rspData", rspData, memDataIn);
    if (curOwner >= 0) begin
      checkVal("memOpm", memOpm, {11'h0, opmOf(curOwner)});
      checkVal("memAddr", memAddr, addrOf(curOwner));
      checkVal("memAddrB", memAddrB, reqAddrB[curOwner*AW +: AW]);
      checkVal("memDataOut", memDataOut, reqData[curOwner*DW +: DW]);
      checkVal("grantId", grantId, curOwner);
    end else begin
      checkVal("idle_memOpm", memOpm, 0);
      checkVal("idle_memAddr", memAddr, 0);
      checkVal("idle_memAddrB", memAddrB, 0);
      checkVal("idle_memDataOut", memDataOut, 0);
    end
    for (int p = 0; p < N; p++)
      checkVal($sformatf("rspOK%0d", p), rspOK[p*2 +: 2], (p == curOwner) ? memOK : 2'd0);
  endtask

  task automatic setReq(input int p, input logic [4:0] opm, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    reqOpm[p*5 +: 5]    = opm;
    reqAddr[p*AW +: AW] = a;
    reqAddrB[p*AW +: AW] = {$urandom, $urandom};
    reqData[p*DW +: DW] = d;
  endtask

  task automatic randReq(input int p);
    logic [4:0] o;
    o = ($urandom_range(0, 7) == 0) ? 5'h1F : 5'($urandom_range(1, 30));
    setReq(p, o, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic randSched();
    int n;
    n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) begin
      schedOk[i]  = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd2;
      schedDat[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    schedOk[n]  = 2'd1;
    schedDat[n] = {$urandom, $urandom, $urandom, $urandom};
    schedLen    = n + 1;
  endtask

  // One full transaction, starting in an IDLE cycle with at least one request pending.
  task automatic doTxn();
    int g;
    g = pickGrant();
    curOwner = g;
    for (int c = 0; c < schedLen; c++) begin
      memOK     = schedOk[c];
      memDataIn = schedDat[c];
      settle();
      checkCycle();
      tick();
    end
    reqOpm[g*5 +: 5] = 5'h00;
    memOK     = 2'd0;
    memDataIn = 128'hFFFF;
    settle();
    checkVal("rel_memOpm", memOpm, 0);
    checkVal("rel_exc", regOutExc, excExp);
`ifdef MEM_L1_ARB_FASTDONE_EN
    if (schedLen > 1) begin
      checkVal("done_rspData", rspData, schedDat[schedLen-1]);
      checkVal("done_rspOK", rspOK[g*2 +: 2], 2'd1);
    end
`endif
    tick();
    curOwner = -1;
    rrPtr    = (g + 1) % N;
  endtask

  task automatic doReset();
    reset  = 1'b1;
    reqOpm = '0;
    memOK  = 2'd0;
    curOwner = -1;
    tick();
    tick();
    reset = 1'b0;
    rrPtr = 0;
  endtask

  initial begin
    reset = 1'b1; reqAddr = '0; reqAddrB = '0; reqOpm = '0; reqData = '0;
    memDataIn = '0; memOK = 2'd0; rrPtr = 0; curOwner = -1; excExp = 64'h0;
    doReset();
    memDataIn = 128'h5A5A;
    settle();
    checkCycle();
    tick();

    // Ports 0 and 2 load together out of reset: 0 first, then 2
    setReq(0, 5'h01, 48'h4000, '0);
    setReq(2, 5'h01, 48'h4800, '0);
    schedOk[0] = 2'd2; schedDat[0] = 128'h1; schedOk[1] = 2'd1; schedDat[1] = 128'h1234;
    schedLen = 2;
    doTxn();
    doTxn();

    // Port 1 store with three HOLD cycles
    setReq(1, 5'h02, 48'h0000_1000, {16{8'hA5}});
    for (int i = 0; i < 3; i++) begin schedOk[i] = 2'd2; schedDat[i] = 128'h0; end
    schedOk[3] = 2'd1; schedDat[3] = 128'h77; schedLen = 4;
    doTxn();

    // Critical then non-critical bus fault
    setReq(0, 5'h01, 48'h0000_2000, '0);
    schedOk[0] = 2'd2; schedDat[0] = 128'h0;
    schedOk[1] = 2'd3; schedDat[1] = 128'h8003;
    schedOk[2] = 2'd3; schedDat[2] = 128'h0003;
    schedOk[3] = 2'd1; schedDat[3] = 128'h9;
    schedLen = 4;
    doTxn();

    // Requester-raised fault, addr[1] set
    setReq(2, 5'h1F, 48'h3002, '0);
    schedOk[0] = 2'd2; schedDat[0] = 128'h0; schedOk[1] = 2'd1; schedDat[1] = 128'h0;
    schedLen = 2;
    doTxn();

    // All ports requesting continuously: fair rotation
    for (int p = 0; p < N; p++) setReq(p, 5'h01, 48'(p * 16'h100), '0);
    for (int k = 0; k < 4; k++) begin
      int o;
      o = pickGrant();
      randSched();
      doTxn();
      setReq(o, 5'h01, 48'(o * 16'h100), '0);
    end

    // Reset in the middle of a HOLD; pending requests re-arbitrated from port 0
    curOwner = pickGrant();
    memOK = 2'd2;
    settle(); checkCycle(); tick();
    settle(); checkCycle();
    reset = 1'b1;
    tick();
    curOwner = -1;
    settle();
    checkCycle();
    tick();
    reset = 1'b0;
    memOK = 2'd0;
    rrPtr = 0;
    randSched();
    doTxn();

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      for (int p = 0; p < N; p++)
        if (opmOf(p) == 5'h00 && $urandom_range(0, 2) == 0) randReq(p);
      if (anyReq()) begin
        randSched();
        doTxn();
      end else begin
        memOK = 2'd0;
        memDataIn = {$urandom, $urandom, $urandom, $urandom};
        settle();
        checkCycle();
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
